queue_word_packer: RTL and testbench

// - Downstream consumer of the 16-bit queue: pops words via the queue read/empty interface and packs

---
 rtl/queue_word_packer.sv | 83 ++++++++
 tb/tb_queue_word_packer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_word_packer.sv
// queue_word_packer: pops DATA_W-bit queue words and packs PACK_RATIO of them into one valid/ready word.
// Optional build macro QUEUE_PACKER_CNT_EN adds out_count, the number of output words accepted since reset.
module queue_word_packer #(
   parameter  int DATA_W     = 16,
   parameter  int PACK_RATIO = 2,
   localparam int CW         = $clog2(PACK_RATIO + 1)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [DATA_W-1:0]            q_dout,
   input  logic                         q_empty,
   output logic                         q_read,
   input  logic                         flush,
   output logic [DATA_W*PACK_RATIO-1:0] out_data,
   output logic [CW-1:0]                out_words,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         busy
`ifdef QUEUE_PACKER_CNT_EN
   ,
   output logic [31:0]                  out_count
`endif
);
   logic [PACK_RATIO-1:0][DATA_W-1:0] slot_q, slot_d, packed_w;
   logic [DATA_W*PACK_RATIO-1:0]      out_data_q, out_data_d;
   logic [CW-1:0]                     fill_cnt_q, fill_cnt_d, out_words_q, out_words_d;
   logic                              inflight_q, flush_pend_q, flush_pend_d, out_valid_q, out_valid_d;
   logic                              full, xfer;

   always_comb begin
      full         = fill_cnt_q == CW'(PACK_RATIO);
      xfer         = (full || (flush_pend_q && fill_cnt_q != '0 && !inflight_q)) && (!out_valid_q || out_ready);
      // reset_n gates the pop so the queue is never drained while the packer is held in reset
      q_read       = reset_n && !q_empty && !flush_pend_q && !xfer && (fill_cnt_q + CW'(inflight_q)) < CW'(PACK_RATIO);
      slot_d       = slot_q;
      packed_w     = '0;
      for (int i = 0; i < PACK_RATIO; i++) begin
         if (inflight_q && fill_cnt_q == CW'(i)) slot_d[i] = q_dout;
         if (fill_cnt_q > CW'(i)) packed_w[i] = slot_q[i];
      end
      fill_cnt_d   = xfer ? '0 : fill_cnt_q + CW'(inflight_q);
      flush_pend_d = !xfer && (flush_pend_q || (flush && (fill_cnt_q != '0 || inflight_q)));
      out_valid_d  = xfer || (out_valid_q && !out_ready);
      out_data_d   = xfer ? packed_w : out_data_q;
      out_words_d  = xfer ? fill_cnt_q : out_words_q;
      busy         = fill_cnt_q != '0 || inflight_q || out_valid_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot_q       <= '0;
         fill_cnt_q   <= '0;
         inflight_q   <= 1'b0;
         flush_pend_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_words_q  <= '0;
      end else begin
         slot_q       <= slot_d;
         fill_cnt_q   <= fill_cnt_d;
         inflight_q   <= q_read;
         flush_pend_q <= flush_pend_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_words_q  <= out_words_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_words = out_words_q;
   assign out_valid = out_valid_q;

`ifdef QUEUE_PACKER_CNT_EN
   logic [31:0] out_count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) out_count_q <= '0;
      else          out_count_q <= out_count_q + 32'(out_valid_q && out_ready);
   end

   assign out_count = out_count_q;
`endif
endmodule

// File: tb/tb_queue_word_packer.sv
// tb_queue_word_packer: table, directed and randomised checks of queue_word_packer at PACK_RATIO=2
// against a bench-side queue and a popped-word stream model.
module tb_queue_word_packer;
   localparam int DW = 16, PR = 2, CW = $clog2(PR + 1);

   logic clk = 1'b0, reset_n = 1'b0, q_empty = 1'b1, flush = 1'b0, out_ready = 1'b1;
   logic q_read, out_valid, busy;
   logic [DW-1:0] q_dout = '0;
   logic [DW*PR-1:0] out_data;
   logic [CW-1:0] out_words;
`ifdef QUEUE_PACKER_CNT_EN
   logic [31:0] out_count;
`endif

   int n_cmp = 0, n_bad = 0, n_pops = 0, n0;
   logic [DW-1:0] mq[$];
   logic [DW-1:0] pq[$];
   bit sb_on = 1'b0, prev_hold = 1'b0, flush_flag = 1'b0;
   logic [DW*PR-1:0] exp_d = '0;
   int exp_w = 0;

   typedef struct {
      logic rdy, fl, qr, ov;
      logic [31:0] data;
      logic [1:0] words;
      logic bsy;
   } vec_t;
   vec_t tv[10];

   always #5 clk = ~clk;

   queue_word_packer #(.DATA_W(DW), .PACK_RATIO(PR)) dut (
      .clk(clk), .reset_n(reset_n), .q_dout(q_dout), .q_empty(q_empty), .q_read(q_read),
      .flush(flush), .out_data(out_data), .out_words(out_words), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy)
`ifdef QUEUE_PACKER_CNT_EN
      , .out_count(out_count)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // One clock: sample before the edge, model the 1-cycle queue read latency after it.
   task automatic tick();
      logic pop;
      #1;
      pop = q_read;
      chk("q_read_while_empty", 64'(pop & q_empty), 64'd0);
      if (sb_on) begin
         if (out_valid && !prev_hold) begin
            exp_w = int'(out_words);
            chk("rnd_words_legal", (exp_w >= 1 && exp_w <= PR && (exp_w == PR || flush_flag)) ? 64'd1 : 64'd0, 64'd1);
            if (exp_w < 1 || exp_w > PR) exp_w = PR;
            chk("rnd_pq_depth", (pq.size() >= exp_w) ? 64'd1 : 64'd0, 64'd1);
            exp_d = '0;
            for (int i = 0; i < exp_w; i++) if (i < pq.size()) exp_d[i*DW +: DW] = pq[i];
            flush_flag = 1'b0;
         end
         if (prev_hold) chk("rnd_hold_valid", 64'(out_valid), 64'd1);
         if (out_valid) begin
            chk("rnd_data", 64'(out_data), 64'(exp_d));
            chk("rnd_words", 64'(out_words), 64'(exp_w));
         end
         if (flush) flush_flag = 1'b1;
         if (out_valid && out_ready) repeat (exp_w) if (pq.size() != 0) void'(pq.pop_front());
         prev_hold = out_valid && !out_ready;
      end
      @(posedge clk);
      #1;
      flush = 1'b0;
      if (pop && mq.size() != 0) begin
         q_dout = mq.pop_front();
         pq.push_back(q_dout);
         n_pops++;
      end
      q_empty = mq.size() == 0;
      @(negedge clk);
   endtask

   task automatic wait_valid(input string name, input int lim);
      int k = 0;
      while (!out_valid && k < lim) begin
         tick();
         k++;
      end
      chk(name, 64'(out_valid), 64'd1);
   endtask

   task automatic push(input logic [DW-1:0] w);
      mq.push_back(w);
      q_empty = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tv[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        2'd0, 1'b0};
      tv[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        2'd0, 1'b1};
      tv[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0, 1'b1};
      tv[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0, 1'b1};
      tv[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h000A0064, 2'd2, 1'b1};
      tv[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h000A0064, 2'd2, 1'b1};
      tv[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h000A0064, 2'd2, 1'b1};
      tv[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h000A0064, 2'd2, 1'b1};
      tv[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h002800FA, 2'd2, 1'b1};
      tv[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h002800FA, 2'd2, 1'b0};

      // reset held with a non-empty queue
      push(16'h1);
      push(16'h2);
      repeat (3) begin
         tick();
         chk("rst_q_read", 64'(q_read), 64'd0);
         chk("rst_valid", 64'(out_valid), 64'd0);
         chk("rst_data", 64'(out_data), 64'd0);
         chk("rst_words", 64'(out_words), 64'd0);
         chk("rst_busy", 64'(busy), 64'd0);
      end
      mq.delete();
      q_empty = 1'b1;
      reset_n = 1'b1;
      n_pops = 0;

      // two full words with out_ready=1, cycle by cycle
      push(16'd100); push(16'd10); push(16'd250); push(16'd40);
      for (int i = 0; i < 10; i++) begin
         out_ready = tv[i].rdy;
         flush = tv[i].fl;
         #1;
         chk($sformatf("t%0d_q_read", i), 64'(q_read), 64'(tv[i].qr));
         chk($sformatf("t%0d_valid", i), 64'(out_valid), 64'(tv[i].ov));
         chk($sformatf("t%0d_data", i), 64'(out_data), 64'(tv[i].data));
         chk($sformatf("t%0d_words", i), 64'(out_words), 64'(tv[i].words));
         chk($sformatf("t%0d_busy", i), 64'(busy), 64'(tv[i].bsy));
         tick();
      end
      chk("case2_pops", 64'(n_pops), 64'd4);
`ifdef QUEUE_PACKER_CNT_EN
      chk("case2_count", 64'(out_count), 64'd2);
`endif

      // single word flushed out, then a flush with nothing collected
      push(16'd7);
      tick(); tick();
      flush = 1'b1;
      tick();
      wait_valid("flush1_wait", 10);
      chk("flush1_data", 64'(out_data), 64'h7);
      chk("flush1_words", 64'(out_words), 64'd1);
      tick();
      flush = 1'b1;
      tick();
      repeat (4) begin
         chk("idle_flush_valid", 64'(out_valid), 64'd0);
         chk("idle_flush_busy", 64'(busy), 64'd0);
         tick();
      end

      // backpressure
      out_ready = 1'b0;
      n0 = n_pops;
      for (int i = 1; i <= 5; i++) push(DW'(i));
      wait_valid("bp_wait", 10);
      repeat (4) tick();
      repeat (4) begin
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_data", 64'(out_data), 64'h00020001);
         chk("bp_q_read", 64'(q_read), 64'd0);
         tick();
      end
      chk("bp_pops", 64'(n_pops - n0), 64'd4);
      out_ready = 1'b1;
      tick();
      chk("bp_next_valid", 64'(out_valid), 64'd1);
      chk("bp_next_data", 64'(out_data), 64'h00040003);
      chk("bp_next_words", 64'(out_words), 64'd2);
      tick(); tick();
      flush = 1'b1;
      wait_valid("bp_tail_wait", 10);
      chk("bp_tail_data", 64'(out_data), 64'h5);
      chk("bp_tail_words", 64'(out_words), 64'd1);
      tick();

      // flush in the same cycle as the pop of the second word
      push(16'd9);
      tick(); tick();
      push(16'd5); push(16'd6);
      flush = 1'b1;
      n0 = n_pops;
      tick();
      wait_valid("race_wait", 10);
      chk("race_data", 64'(out_data), 64'h00050009);
      chk("race_words", 64'(out_words), 64'd2);
      chk("race_pops", 64'(n_pops - n0), 64'd1);
      tick();

      // reset with one word captured and one in flight
      push(16'd21); push(16'd22);
      tick();
      reset_n = 1'b0;
      #1;
      chk("mid_rst_q_read", 64'(q_read), 64'd0);
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_data", 64'(out_data), 64'd0);
      chk("mid_rst_words", 64'(out_words), 64'd0);
`ifdef QUEUE_PACKER_CNT_EN
      chk("mid_rst_count", 64'(out_count), 64'd0);
`endif
      tick(); tick();
      reset_n = 1'b1;
      push(16'd23);
      wait_valid("post_rst_wait", 12);
      chk("post_rst_data", 64'(out_data), 64'h00170016);
      chk("post_rst_words", 64'(out_words), 64'd2);
      repeat (3) tick();

      // randomised traffic against the popped-stream model
      pq.delete();
      prev_hold = 1'b0;
      flush_flag = 1'b0;
      sb_on = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 2) == 0 && mq.size() < 8) push(DW'($urandom));
         out_ready = $urandom_range(0, 3) != 0;
         flush = $urandom_range(0, 9) == 0;
         tick();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 300 && !(mq.size() == 0 && !busy); k++) begin
         flush = (k % 8) == 0;
         tick();
      end
      chk("drain_busy", 64'(busy), 64'd0);
      chk("drain_queue", 64'(mq.size()), 64'd0);
      chk("drain_stream", 64'(pq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
